// File: rtl/multdiv_seq_unit.sv
// Sequential signed multiplier (32x16, 16 cycles) / divider (32/16, 32 cycles) with start/ready handshake.
// Define MULTDIV_RESIDUE_EN to add registered mod-31 residue outputs for the downstream residue checker.
module multdiv_seq_unit #(
  parameter logic [4:0] OPCODE_MULT = 5'b00110,
  parameter logic [4:0] OPCODE_DIV  = 5'b00111
`ifdef MULTDIV_RESIDUE_EN
  ,
  parameter int unsigned RES_BITS = 5
`endif
) (
  input  logic        inClock,
  input  logic        inResetN,
  input  logic        inStart,
  input  logic [4:0]  inOpcode,
  input  logic [31:0] inA,
  input  logic [15:0] inB,
  output logic        outBusy,
  output logic        outResultReady,
  output logic [31:0] outResult,
  output logic [31:0] outRemainder,
  output logic [4:0]  outOpcode,
  output logic        outOverflow,
  output logic        outDivByZero
`ifdef MULTDIV_RESIDUE_EN
  ,
  output logic [RES_BITS-1:0] outResultResidue,
  output logic [RES_BITS-1:0] outRemainderResidue
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_MULT, S_DIV, S_DONE} state_t;

  state_t      state, state_nxt;
  logic [5:0]  cnt;
  logic [4:0]  op_q;
  logic [47:0] acc, mcand, acc_nxt;
  logic [15:0] mplier;
  logic [31:0] rem, quo, dvs, rem_nxt, quo_nxt;
  logic [32:0] rem_sh, diff;
  logic        sign_q, sign_r, ovf_div;
  logic        accept, is_mult, is_div;
  logic        load_out, ovf_nxt, dz_nxt;
  logic [31:0] res_nxt, remout_nxt;
  logic [31:0] mag_a, mag_b, b_ext;

  // Generate/propagate adder used for every two's-complement negate.
  function automatic logic [31:0] cla_add32(input logic [31:0] x, input logic [31:0] y,
                                            input logic cin);
    logic [31:0] g, p, c;
    g    = x & y;
    p    = x ^ y;
    c[0] = cin;
    for (int i = 0; i < 31; i++) c[i+1] = g[i] | (p[i] & c[i]);
    return p ^ c;
  endfunction

  function automatic logic [31:0] neg32(input logic [31:0] x);
    return cla_add32(~x, 32'd0, 1'b1);
  endfunction

  assign is_mult = (inOpcode == OPCODE_MULT);
  assign is_div  = (inOpcode == OPCODE_DIV);
  assign accept  = inStart && (state == S_IDLE || state == S_DONE) && (is_mult || is_div);
  assign b_ext   = {{16{inB[15]}}, inB};
  assign mag_a   = inA[31] ? neg32(inA) : inA;
  assign mag_b   = inB[15] ? neg32(b_ext) : b_ext;

  assign outBusy        = (state == S_MULT) || (state == S_DIV);
  assign outResultReady = (state == S_DONE);

  // One iteration step; the top multiplier bit carries negative weight, so it subtracts.
  always_comb begin
    // NOTE: every always_comb target gets a default first so no path leaves it unassigned (no latch).
    acc_nxt = acc;
    if (mplier[0]) acc_nxt = (cnt == 6'd15) ? acc - mcand : acc + mcand;
    rem_sh  = {rem, quo[31]};
    diff    = rem_sh - {1'b0, dvs};
    rem_nxt = diff[32] ? rem_sh[31:0] : diff[31:0];
    quo_nxt = {quo[30:0], ~diff[32]};
  end

  always_comb begin
    state_nxt  = state;
    load_out   = 1'b0;
    res_nxt    = 32'd0;
    remout_nxt = 32'd0;
    ovf_nxt    = 1'b0;
    dz_nxt     = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        state_nxt = S_IDLE;
        if (accept) begin
          if (is_mult) begin
            state_nxt = S_MULT;
          end else if (inB != 16'd0) begin
            state_nxt = S_DIV;
          end else begin
            state_nxt  = S_DONE;
            load_out   = 1'b1;
            remout_nxt = inA;
            dz_nxt     = 1'b1;
          end
        end
      end
      S_MULT: begin
        if (cnt == 6'd15) begin
          state_nxt = S_DONE;
          load_out  = 1'b1;
          res_nxt   = acc_nxt[31:0];
          ovf_nxt   = !((&acc_nxt[47:31]) || !(|acc_nxt[47:31]));
        end
      end
      S_DIV: begin
        if (cnt == 6'd31) begin
          state_nxt  = S_DONE;
          load_out   = 1'b1;
          res_nxt    = sign_q ? neg32(quo_nxt) : quo_nxt;
          remout_nxt = sign_r ? neg32(rem_nxt) : rem_nxt;
          ovf_nxt    = ovf_div;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

`ifdef MULTDIV_RESIDUE_EN
  // Mod-31 residue: sum the 5-bit chunks, fold carries back in twice, report 31 as 0.
  function automatic logic [4:0] res31(input logic [31:0] x);
    logic [7:0] s;
    s = 8'(x[4:0]) + 8'(x[9:5]) + 8'(x[14:10]) + 8'(x[19:15])
      + 8'(x[24:20]) + 8'(x[29:25]) + 8'(x[31:30]);
    s = 8'(s[4:0]) + 8'(s[7:5]);
    s = 8'(s[4:0]) + 8'(s[7:5]);
    return (s[4:0] == 5'd31) ? 5'd0 : s[4:0];
  endfunction
`endif

  always_ff @(posedge inClock) begin
    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    if (!inResetN) begin
      state        <= S_IDLE;
      cnt          <= 6'd0;
      outResult    <= 32'd0;
      outRemainder <= 32'd0;
      outOpcode    <= 5'd0;
      outOverflow  <= 1'b0;
      outDivByZero <= 1'b0;
`ifdef MULTDIV_RESIDUE_EN
      outResultResidue    <= '0;
      outRemainderResidue <= '0;
`endif
    end else begin
      state <= state_nxt;
      cnt   <= accept ? 6'd0 : (outBusy ? cnt + 6'd1 : cnt);
      if (load_out) begin
        outResult    <= res_nxt;
        outRemainder <= remout_nxt;
        outOpcode    <= accept ? inOpcode : op_q;
        outOverflow  <= ovf_nxt;
        outDivByZero <= dz_nxt;
`ifdef MULTDIV_RESIDUE_EN
        outResultResidue    <= res31(res_nxt);
        outRemainderResidue <= res31(remout_nxt);
`endif
      end
    end
  end

  // NOTE: datapath registers carry no reset; accept always loads them before any iteration reads them.
  always_ff @(posedge inClock) begin
    if (accept) begin
      op_q    <= inOpcode;
      acc     <= 48'd0;
      mcand   <= {{16{inA[31]}}, inA};
      mplier  <= inB;
      rem     <= 32'd0;
      quo     <= mag_a;
      dvs     <= mag_b;
      sign_q  <= inA[31] ^ inB[15];
      sign_r  <= inA[31];
      ovf_div <= (inA == 32'h8000_0000) && (inB == 16'hFFFF);
    end else if (state == S_MULT) begin
      acc    <= acc_nxt;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end else if (state == S_DIV) begin
      rem <= rem_nxt;
      quo <= quo_nxt;
    end
  end

endmodule

// File: tb/tb_multdiv_seq_unit.sv
// Directed self-checking bench for multdiv_seq_unit; expected values are hand-computed constants.
// Residue outputs are checked against a % model when MULTDIV_RESIDUE_EN is defined.
module tb_multdiv_seq_unit;

  localparam logic [4:0] OP_MULT = 5'b00110;
  localparam logic [4:0] OP_DIV  = 5'b00111;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [4:0]  opcode = 5'd0;
  logic [31:0] a = 32'd0;
  logic [15:0] b = 16'd0;
  logic        busy, ready, overflow, div_by_zero;
  logic [31:0] result, remainder;
  logic [4:0]  op_out;
`ifdef MULTDIV_RESIDUE_EN
  logic [4:0]  result_res, remainder_res;
`endif

  int errors = 0;
  int checks = 0;
  int lat;
  int pulses;

  always #5 clk = ~clk;

  multdiv_seq_unit dut (
    .inClock        (clk),
    .inResetN       (rst_n),
    .inStart        (start),
    .inOpcode       (opcode),
    .inA            (a),
    .inB            (b),
    .outBusy        (busy),
    .outResultReady (ready),
    .outResult      (result),
    .outRemainder   (remainder),
    .outOpcode      (op_out),
    .outOverflow    (overflow),
    .outDivByZero   (div_by_zero)
`ifdef MULTDIV_RESIDUE_EN
    ,
    .outResultResidue    (result_res),
    .outRemainderResidue (remainder_res)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] res_model(input logic [31:0] v);
    return v % 32'd31;
  endfunction

  // Starts at a negedge; returns at the negedge of the ready cycle (or after the cycle budget).
  task automatic run_op(input logic [4:0] op, input logic [31:0] av, input logic [15:0] bv,
                        output int cycles);
    start = 1'b1; opcode = op; a = av; b = bv;
    @(posedge clk);
    #1 start = 1'b0;
    cycles = 1;
    @(negedge clk);
    while (!ready && cycles < 100) begin
      @(negedge clk);
      cycles++;
    end
  endtask

  task automatic check_out(input string tag, input int cycles, input int exp_cycles,
                           input logic [31:0] er, input logic [31:0] erm, input logic [4:0] eop,
                           input logic eovf, input logic edz, input bit linger);
    check({tag, ".ready"}, 32'(ready), 32'd1);
    check({tag, ".latency"}, cycles, exp_cycles);
    check({tag, ".result"}, result, er);
    check({tag, ".remainder"}, remainder, erm);
    check({tag, ".opcode"}, 32'(op_out), 32'(eop));
    check({tag, ".overflow"}, 32'(overflow), 32'(eovf));
    check({tag, ".div_by_zero"}, 32'(div_by_zero), 32'(edz));
`ifdef MULTDIV_RESIDUE_EN
    check({tag, ".result_res"}, 32'(result_res), res_model(er));
    check({tag, ".remainder_res"}, 32'(remainder_res), res_model(erm));
`endif
    if (linger) begin
      @(negedge clk);
      check({tag, ".ready_pulse"}, 32'(ready), 32'd0);
      check({tag, ".idle_busy"}, 32'(busy), 32'd0);
      check({tag, ".hold"}, result, er);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("reset.busy", 32'(busy), 32'd0);
    check("reset.ready", 32'(ready), 32'd0);
    check("reset.result", result, 32'd0);
    check("reset.remainder", remainder, 32'd0);
    check("reset.opcode", 32'(op_out), 32'd0);
    check("reset.flags", {30'd0, overflow, div_by_zero}, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op(OP_MULT, 32'd7, 16'hFFFD, lat);
    check_out("mul_7_m3", lat, 17, 32'hFFFF_FFEB, 32'd0, OP_MULT, 1'b0, 1'b0, 1'b1);

    run_op(OP_DIV, 32'hFFFF_FF9C, 16'd7, lat);
    check_out("div_m100_7", lat, 33, 32'hFFFF_FFF2, 32'hFFFF_FFFE, OP_DIV, 1'b0, 1'b0, 1'b1);

    run_op(OP_MULT, 32'h4000_0000, 16'd4, lat);
    check_out("mul_ovf", lat, 17, 32'h0000_0000, 32'd0, OP_MULT, 1'b1, 1'b0, 1'b1);

    run_op(OP_DIV, 32'd5, 16'd0, lat);
    check_out("div_by_0", lat, 1, 32'd0, 32'd5, OP_DIV, 1'b0, 1'b1, 1'b1);

    run_op(OP_DIV, 32'h8000_0000, 16'hFFFF, lat);
    check_out("div_min_m1", lat, 33, 32'h8000_0000, 32'd0, OP_DIV, 1'b1, 1'b0, 1'b1);

    run_op(OP_DIV, 32'd100, 16'hFFF9, lat);
    check_out("div_100_m7", lat, 33, 32'hFFFF_FFF2, 32'd2, OP_DIV, 1'b0, 1'b0, 1'b1);

    run_op(OP_MULT, 32'hFFFF_FFFB, 16'h8000, lat);
    check_out("mul_m5_min16", lat, 17, 32'h0002_8000, 32'd0, OP_MULT, 1'b0, 1'b0, 1'b1);

    run_op(OP_MULT, 32'd8, 16'd4, lat);
    check_out("mul_8_4", lat, 17, 32'd32, 32'd0, OP_MULT, 1'b0, 1'b0, 1'b1);

    // Second start while MULT is iterating must be ignored
    start = 1'b1; opcode = OP_MULT; a = 32'd3; b = 16'd5;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 1;
    @(negedge clk);
    repeat (4) begin
      @(negedge clk);
      lat++;
    end
    check("ignored.busy", 32'(busy), 32'd1);
    start = 1'b1; opcode = OP_DIV; a = 32'd100; b = 16'd3;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    lat++;
    while (!ready && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    check_out("ignored", lat, 17, 32'd15, 32'd0, OP_MULT, 1'b0, 1'b0, 1'b1);

    // Unsupported opcode is not accepted
    start = 1'b1; opcode = 5'b00000; a = 32'd9; b = 16'd9;
    @(posedge clk);
    #1 start = 1'b0;
    @(negedge clk);
    check("badop.busy", 32'(busy), 32'd0);
    @(negedge clk);
    check("badop.busy2", 32'(busy), 32'd0);
    check("badop.ready", 32'(ready), 32'd0);
    check("badop.hold", result, 32'd15);

    // Back-to-back: start issued during the DONE cycle
    run_op(OP_MULT, 32'd2, 16'd3, lat);
    check_out("b2b_first", lat, 17, 32'd6, 32'd0, OP_MULT, 1'b0, 1'b0, 1'b0);
    run_op(OP_MULT, 32'd6, 16'hFFF9, lat);
    check_out("b2b_second", lat, 17, 32'hFFFF_FFD6, 32'd0, OP_MULT, 1'b0, 1'b0, 1'b1);

    run_op(OP_DIV, 32'd7, 16'd0, lat);
    check_out("div7_by_0", lat, 1, 32'd0, 32'd7, OP_DIV, 1'b0, 1'b1, 1'b1);

    // Reset in the middle of a DIV
    start = 1'b1; opcode = OP_DIV; a = 32'd1000; b = 16'd3;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(negedge clk);
    check("midrst.busy_before", 32'(busy), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst.busy", 32'(busy), 32'd0);
    check("midrst.ready", 32'(ready), 32'd0);
    check("midrst.result", result, 32'd0);
    check("midrst.remainder", remainder, 32'd0);
    check("midrst.opcode", 32'(op_out), 32'd0);
    check("midrst.flags", {30'd0, overflow, div_by_zero}, 32'd0);
`ifdef MULTDIV_RESIDUE_EN
    check("midrst.residues", {22'd0, result_res, remainder_res}, 32'd0);
`endif
    rst_n = 1'b1;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (ready) pulses++;
    end
    check("midrst.no_pulse", pulses, 0);

    run_op(OP_MULT, 32'd12, 16'd12, lat);
    check_out("after_rst", lat, 17, 32'd144, 32'd0, OP_MULT, 1'b0, 1'b0, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
